tc_param_stack: RTL and testbench

TC_PARAM_STACK -- requirements
Module: tc_param_stack

---
 rtl/tc_param_stack.sv | 122 ++++++++++++
 tb/tb_tc_param_stack.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tc_param_stack.sv
`timescale 1ns/1ps
// tc_param_stack: LIFO stack of DEPTH entries of WIDTH bits, with a
// combinational top-of-stack view and one-cycle overflow/underflow pulses.
// UUID and NAME are tooling labels only and have no functional effect.
module tc_param_stack #(
    parameter int  UUID  = 0,
    parameter      NAME  = "",
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 256,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    // Index width for the storage array; always <= CW since DEPTH >= 2.
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic [CW-1:0]    sp_nxt;
    logic [AW-1:0]    sp_idx;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             wr_en;
    logic             ovf_nxt;
    logic             unf_nxt;
    logic             is_empty;
    logic             is_full;
    logic             unused_params;

    assign unused_params = (UUID != 0) || (NAME != "");

    assign is_empty = (sp == '0);
    assign is_full  = (sp == DEPTH_C);

    // sp never exceeds DEPTH, so its low AW bits address every slot, and
    // whenever sp > 0 the AW-bit difference below equals sp-1 exactly.
    assign sp_idx  = sp[AW-1:0];
    assign top_idx = sp_idx - AW'(1);

    // Decode push/pop into the next pointer, a write slot and the error flags.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        sp_nxt  = sp;
        wr_en   = 1'b0;
        wr_idx  = sp_idx;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (is_full) begin
                    ovf_nxt = 1'b1;
                end else begin
                    wr_en  = 1'b1;
                    sp_nxt = sp + ONE;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    unf_nxt = 1'b1;
                end else begin
                    sp_nxt = sp - ONE;
                end
            end
            2'b11: begin
                // Empty: the push still lands in slot 0, only the pop is refused.
                // Otherwise the top entry is replaced in place.
                wr_en = 1'b1;
                if (is_empty) begin
                    sp_nxt  = ONE;
                    unf_nxt = 1'b1;
                end else begin
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
    end

    // Pointer and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before this edge.
        if (rst) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_nxt;
            overflow  <= ovf_nxt;
            underflow <= unf_nxt;
        end
    end

    // Storage write port; a push in a reset cycle is discarded.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; slots at or above sp are
        // never shown on out, so stale contents are unobservable.
        if (wr_en && !rst) begin
            mem[wr_idx] <= in;
        end
    end

    assign out   = is_empty ? '0 : mem[top_idx];
    assign count = sp;
    assign empty = is_empty;
    assign full  = is_full;

endmodule

// File: tb/tb_tc_param_stack.sv
`timescale 1ns/1ps
// Self-checking bench for tc_param_stack: directed vectors on an 8x4 stack,
// then random traffic on the 8x4 and a 1x5 stack against a reference model.
// Stimulus pushes expected observations into scoreboards; a monitor compares.
module tb_tc_param_stack;

    typedef struct packed {
        logic [7:0] out;
        logic [7:0] count;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       push_a = 1'b0, pop_a = 1'b0;
    logic [7:0] in_a   = 8'h00;
    logic [7:0] out_a;
    logic [2:0] count_a;
    logic       empty_a, full_a, overflow_a, underflow_a;

    logic       push_b = 1'b0, pop_b = 1'b0;
    logic [0:0] in_b   = 1'b0;
    logic [0:0] out_b;
    logic [2:0] count_b;
    logic       empty_b, full_b, overflow_b, underflow_b;

    tc_param_stack #(.UUID(1), .NAME("stk_a"), .WIDTH(8), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .push(push_a), .pop(pop_a), .in(in_a),
        .out(out_a), .count(count_a), .empty(empty_a), .full(full_a),
        .overflow(overflow_a), .underflow(underflow_a)
    );

    tc_param_stack #(.UUID(2), .NAME("stk_b"), .WIDTH(1), .DEPTH(5)) dut_b (
        .clk(clk), .rst(rst), .push(push_b), .pop(pop_b), .in(in_b),
        .out(out_b), .count(count_b), .empty(empty_b), .full(full_b),
        .overflow(overflow_b), .underflow(underflow_b)
    );

    obs_t got_a, got_b;
    assign got_a = {out_a, 5'b0, count_a, full_a, empty_a, overflow_a, underflow_a};
    assign got_b = {7'b0, out_b, 5'b0, count_b, full_b, empty_b, overflow_b, underflow_b};

    int   n_checks = 0;
    int   n_pass   = 0;
    obs_t sb_a[$];
    obs_t sb_b[$];

    // Reference model state: index 0 mirrors dut_a, index 1 mirrors dut_b.
    int stk [2][0:7];
    int sz  [2];

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got out=%0h count=%0d full=%b empty=%b ovf=%b unf=%b, expected out=%0h count=%0d full=%b empty=%b ovf=%b unf=%b",
                     name, got.out, got.count, got.full, got.empty, got.ovf, got.unf,
                     exp.out, exp.count, exp.full, exp.empty, exp.ovf, exp.unf);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Monitor: outputs are stable at the falling edge; compare one entry per cycle.
    initial begin
        int na = 0;
        int nb = 0;
        forever begin
            @(negedge clk);
            if (sb_a.size() != 0) begin
                check($sformatf("a[%0d]", na), got_a, sb_a.pop_front());
                na++;
            end
            if (sb_b.size() != 0) begin
                check($sformatf("b[%0d]", nb), got_b, sb_b.pop_front());
                nb++;
            end
        end
    end

    // Directed cycle on dut_a with a hand-computed expected observation.
    task automatic step_a(input logic r, input logic p, input logic q, input logic [7:0] d,
                          input logic [7:0] eo, input int ec,
                          input logic ef, input logic ee, input logic eov, input logic eun);
        obs_t e;
        rst = r; push_a = p; pop_a = q; in_a = d;
        push_b = 1'b0; pop_b = 1'b0; in_b = 1'b0;
        @(posedge clk);
        #1;
        e.out = eo; e.count = 8'(ec); e.full = ef; e.empty = ee; e.ovf = eov; e.unf = eun;
        sb_a.push_back(e);
    endtask

    // Behavioural stack: reset, push/pop resolution, then derive outputs.
    task automatic model_step(input int k, input logic r, input logic p, input logic q,
                              input int d, input int depth, output obs_t e);
        e = '0;
        if (r) begin
            sz[k] = 0;
        end else if (p && q) begin
            if (sz[k] == 0) begin
                stk[k][0] = d;
                sz[k]     = 1;
                e.unf     = 1'b1;
            end else begin
                stk[k][sz[k]-1] = d;
            end
        end else if (p) begin
            if (sz[k] == depth) begin
                e.ovf = 1'b1;
            end else begin
                stk[k][sz[k]] = d;
                sz[k]++;
            end
        end else if (q) begin
            if (sz[k] == 0) e.unf = 1'b1;
            else            sz[k]--;
        end
        e.count = 8'(sz[k]);
        e.full  = (sz[k] == depth);
        e.empty = (sz[k] == 0);
        e.out   = (sz[k] > 0) ? 8'(stk[k][sz[k]-1]) : 8'h00;
    endtask

    // Random cycle on both stacks; push_pct biases toward filling or draining.
    task automatic rand_step(input bit force_rst, input int push_pct);
        logic       r, pa, qa, pb, qb;
        logic [7:0] da;
        logic [0:0] db;
        obs_t       ea, eb;
        r  = force_rst || ($urandom_range(0, 59) == 0);
        pa = ($urandom_range(0, 99) < push_pct);
        qa = ($urandom_range(0, 99) >= push_pct);
        pb = ($urandom_range(0, 99) < push_pct);
        qb = ($urandom_range(0, 99) >= push_pct);
        da = 8'($urandom);
        db = 1'($urandom);
        rst = r; push_a = pa; pop_a = qa; in_a = da; push_b = pb; pop_b = qb; in_b = db;
        @(posedge clk);
        #1;
        model_step(0, r, pa, qa, int'(da), 4, ea);
        model_step(1, r, pb, qb, int'(db), 5, eb);
        sb_a.push_back(ea);
        sb_b.push_back(eb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //      rst push pop in      out    cnt full empty ovf unf
        step_a(1, 1, 0, 8'h55, 8'h00, 0, 0, 1, 0, 0);  // reset ignores push
        step_a(0, 1, 0, 8'h11, 8'h11, 1, 0, 0, 0, 0);
        step_a(0, 1, 0, 8'h22, 8'h22, 2, 0, 0, 0, 0);
        step_a(0, 1, 0, 8'h33, 8'h33, 3, 0, 0, 0, 0);
        step_a(0, 1, 0, 8'h44, 8'h44, 4, 1, 0, 0, 0);  // now full
        step_a(0, 1, 0, 8'h55, 8'h44, 4, 1, 0, 1, 0);  // overflow pulse
        step_a(0, 1, 0, 8'h56, 8'h44, 4, 1, 0, 1, 0);  // second rejected push
        step_a(0, 0, 0, 8'h66, 8'h44, 4, 1, 0, 0, 0);  // flag not sticky
        step_a(0, 1, 1, 8'h99, 8'h99, 4, 1, 0, 0, 0);  // replace top at full
        step_a(0, 0, 1, 8'h00, 8'h33, 3, 0, 0, 0, 0);
        step_a(0, 0, 1, 8'h00, 8'h22, 2, 0, 0, 0, 0);
        step_a(0, 0, 1, 8'h00, 8'h11, 1, 0, 0, 0, 0);
        step_a(0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0);
        step_a(0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 0, 1);  // underflow pulse
        step_a(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0);
        step_a(0, 1, 1, 8'h7E, 8'h7E, 1, 0, 0, 0, 1);  // push+pop on empty
        step_a(0, 0, 0, 8'hFF, 8'h7E, 1, 0, 0, 0, 0);  // in not captured
        step_a(0, 1, 0, 8'hAA, 8'hAA, 2, 0, 0, 0, 0);
        step_a(0, 1, 0, 8'hBB, 8'hBB, 3, 0, 0, 0, 0);
        step_a(1, 1, 0, 8'h12, 8'h00, 0, 0, 1, 0, 0);  // mid-sequence reset
        step_a(0, 1, 0, 8'hCC, 8'hCC, 1, 0, 0, 0, 0);
        step_a(0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0);
        step_a(1, 0, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0);  // pop during reset: no flag

        rand_step(1'b1, 50);
        repeat (150) rand_step(1'b0, 65);
        repeat (150) rand_step(1'b0, 40);
        rst = 1'b0; push_a = 1'b0; pop_a = 1'b0; push_b = 1'b0; pop_b = 1'b0;

        repeat (3) @(posedge clk);
        check_int("sb_a_drained", sb_a.size(), 0);
        check_int("sb_b_drained", sb_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
